// File: rtl/gray_wdt_pkg.sv
// Shared definitions for the Gray heartbeat watchdog and the TX heartbeat generator:
// FSM state encoding and a reflected-Gray to binary conversion helper.
package gray_wdt_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      ERROR = 2'd2
   } wdt_state_t;

   localparam int GRAY_MAX_W = 16;

   // Widest supported code; callers zero-extend and truncate to their own width.
   function automatic logic [GRAY_MAX_W-1:0] gray_to_bin(input logic [GRAY_MAX_W-1:0] g);
      logic [GRAY_MAX_W-1:0] b;
      b = g;
      for (int i = 1; i < GRAY_MAX_W; i++) begin
         b = b ^ (g >> i);
      end
      return b;
   endfunction

   function automatic logic [GRAY_MAX_W-1:0] bin_to_gray(input logic [GRAY_MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/gray_hb_wdt_gray2bin.sv
// Combinational reflected-Gray to binary decoder (XOR prefix from the MSB down).
module gray2bin #(
   parameter int WIDTH = 3
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);

   always_comb begin
      bin = gray;
      for (int i = 1; i < WIDTH; i++) begin
         bin = bin ^ (gray >> i);
      end
   end

endmodule

// File: rtl/gray_hb_wdt.sv
// Gray heartbeat watchdog: checks hold/single-step progress and a per-sequence cycle timeout.
// Define HB_SYNC_EN to pass hb through a 2-flop synchroniser before decoding.
module gray_hb_wdt
   import gray_wdt_pkg::*;
#(
   parameter int WIDTH    = 3,
   parameter int TIMEOUT  = 6500000,
   parameter int CNT_W    = 24,
   parameter int GOOD_CYC = 1,
   parameter int FCNT_W   = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [WIDTH-1:0]  hb,
   input  logic              fault_clr,
   output logic              health,
   output logic              err_pulse,
   output logic              to_pulse,
   output logic [FCNT_W-1:0] fault_cnt
);

   localparam int                GOOD_W   = $clog2(GOOD_CYC + 1);
   localparam logic [WIDTH-1:0]  LAST     = '1;
   localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(TIMEOUT - 1);
   localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(GOOD_CYC);

   logic [WIDTH-1:0] hb_d;

`ifdef HB_SYNC_EN
   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= hb;
         sync2 <= sync1;
      end
   end

   assign hb_d = sync2;
`else
   assign hb_d = hb;
`endif

   logic [WIDTH-1:0] idx;

   gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
      .gray (hb_d),
      .bin  (idx)
   );

   wdt_state_t        state;
   wdt_state_t        state_nxt;
   logic [WIDTH-1:0]  cur;
   logic [WIDTH-1:0]  cur_nxt;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  count_nxt;
   logic [GOOD_W-1:0] good;
   logic [GOOD_W-1:0] good_nxt;
   logic              health_nxt;
   logic              err_nxt;
   logic              to_nxt;
   logic              fault;
   logic [FCNT_W-1:0] fcnt_nxt;
   logic [WIDTH-1:0]  succ;
   logic              hold;
   logic              step;
   logic              done;
   logic              tmo;

   assign succ = cur + 1'b1;
   assign hold = (idx == cur);
   assign step = (idx == succ);
   assign done = step && (idx == LAST);
   // A completing step on the last allowed cycle is not a timeout.
   assign tmo  = (count == TO_LAST) && !done;

   always_comb begin
      state_nxt  = state;
      cur_nxt    = cur;
      count_nxt  = count;
      good_nxt   = good;
      health_nxt = health;
      err_nxt    = 1'b0;
      to_nxt     = 1'b0;
      fault      = 1'b0;
      case (state)
         IDLE: begin
            count_nxt  = '0;
            health_nxt = 1'b0;
            if (idx == '0) begin
               state_nxt = TRACK;
               cur_nxt   = '0;
            end
         end
         TRACK: begin
            if (tmo || !(hold || step)) begin
               state_nxt  = ERROR;
               to_nxt     = tmo;
               err_nxt    = !tmo;
               health_nxt = 1'b0;
               good_nxt   = '0;
               count_nxt  = '0;
               fault      = 1'b1;
            end else begin
               cur_nxt = idx;
               if (done) begin
                  count_nxt  = '0;
                  good_nxt   = (good == GOOD_MAX) ? good : good + 1'b1;
                  health_nxt = health | (good_nxt == GOOD_MAX);
               end else begin
                  count_nxt = count + 1'b1;
               end
            end
         end
         ERROR: begin
            count_nxt  = '0;
            health_nxt = 1'b0;
            if (idx == '0) begin
               state_nxt = TRACK;
               cur_nxt   = '0;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt  = IDLE;
            count_nxt  = '0;
            health_nxt = 1'b0;
         end
      endcase
   end

   // Clear wins over increment, but a fault on the clearing edge still counts once.
   always_comb begin
      fcnt_nxt = fault_cnt;
      if (fault_clr) begin
         fcnt_nxt = fault ? FCNT_W'(1) : '0;
      end else if (fault && (fault_cnt != '1)) begin
         fcnt_nxt = fault_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         cur       <= '0;
         count     <= '0;
         good      <= '0;
         health    <= 1'b0;
         err_pulse <= 1'b0;
         to_pulse  <= 1'b0;
         fault_cnt <= '0;
      end else begin
         state     <= state_nxt;
         cur       <= cur_nxt;
         count     <= count_nxt;
         good      <= good_nxt;
         health    <= health_nxt;
         err_pulse <= err_nxt;
         to_pulse  <= to_nxt;
         fault_cnt <= fcnt_nxt;
      end
   end

endmodule

// File: tb/tb_gray_hb_wdt.sv
// Bench for gray_hb_wdt: scenario tasks plus a randomized walk, checked against a position-based model.
module tb_gray_hb_wdt;

   localparam int WIDTH    = 3;
   localparam int TIMEOUT  = 100;
   localparam int CNT_W    = 24;
   localparam int GOOD_CYC = 2;
   localparam int FCNT_W   = 2;
   localparam int N        = 1 << WIDTH;
   localparam int FMAX     = (1 << FCNT_W) - 1;
`ifdef HB_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic              clk       = 1'b0;
   logic              reset_n   = 1'b0;
   logic [WIDTH-1:0]  hb        = '0;
   logic              fault_clr = 1'b0;
   logic              health;
   logic              err_pulse;
   logic              to_pulse;
   logic [FCNT_W-1:0] fault_cnt;

   int checks   = 0;
   int failures = 0;

   gray_hb_wdt #(
      .WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W), .GOOD_CYC(GOOD_CYC), .FCNT_W(FCNT_W)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .hb        (hb),
      .fault_clr (fault_clr),
      .health    (health),
      .err_pulse (err_pulse),
      .to_pulse  (to_pulse),
      .fault_cnt (fault_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: position in the sequence, cycles since last completion, completions seen.
   logic [WIDTH-1:0] pipe_q [2];
   bit m_track, m_recover, m_health, m_err, m_to;
   int m_pos, m_age, m_good, m_fcnt;

   function automatic logic [WIDTH-1:0] code(input int b);
      logic [WIDTH-1:0] v;
      v = WIDTH'(b);
      return v ^ (v >> 1);
   endfunction

   function automatic int pos_of(input logic [WIDTH-1:0] g);
      for (int b = 0; b < N; b++) begin
         if (code(b) == g) return b;
      end
      return -1;
   endfunction

   function automatic logic [FCNT_W+2:0] model_vec();
      return {m_health, m_err, m_to, FCNT_W'(m_fcnt)};
   endfunction

   function automatic logic [FCNT_W+2:0] obs();
      return {health, err_pulse, to_pulse, fault_cnt};
   endfunction

   task automatic model_reset();
      pipe_q[0] = '0; pipe_q[1] = '0;
      m_track = 0; m_recover = 0; m_health = 0; m_err = 0; m_to = 0;
      m_pos = 0; m_age = 0; m_good = 0; m_fcnt = 0;
   endtask

   task automatic model_step();
      logic [WIDTH-1:0] seen;
      int p, nxt;
      bit done, tmo, bad, flt;
      seen = (LAT == 0) ? hb : pipe_q[1];
      pipe_q[1] = pipe_q[0];
      pipe_q[0] = hb;
      p = pos_of(seen);
      m_err = 0; m_to = 0; flt = 0;
      if (m_recover) begin
         m_recover = 0; m_health = 0; m_track = (p == 0); m_pos = 0; m_age = 0;
      end else if (!m_track) begin
         if (p == 0) begin m_track = 1; m_pos = 0; m_age = 0; end
      end else begin
         nxt  = (m_pos + 1) % N;
         done = (p == nxt) && (p == N - 1);
         tmo  = (m_age == TIMEOUT - 1) && !done;
         bad  = (p != m_pos) && (p != nxt);
         if (tmo || bad) begin
            m_to = tmo; m_err = !tmo; m_health = 0; m_good = 0; m_age = 0;
            m_track = 0; m_recover = 1; flt = 1;
         end else begin
            m_pos = p;
            if (done) begin
               m_age = 0;
               if (m_good < GOOD_CYC) m_good++;
               if (m_good == GOOD_CYC) m_health = 1;
            end else begin
               m_age++;
            end
         end
      end
      if (fault_clr) m_fcnt = flt ? 1 : 0;
      else if (flt && m_fcnt < FMAX) m_fcnt++;
   endtask

   task automatic tick(input logic [WIDTH-1:0] g, input logic clr);
      hb = g;
      fault_clr = clr;
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset_n = 1'b0; hb = '0; fault_clr = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      checks++;
      if (obs() !== '0)
         begin failures++; $display("FAIL reset_state got=%b want=%b", obs(), {(FCNT_W+3){1'b0}}); end
      reset_n = 1'b1;
   endtask

   task automatic test_sequences();
      int  first_h = -1;
      bit  pulse_seen = 0;
      for (int t = 0; t < 34 + LAT; t++) begin
         tick(code(t < 32 ? (t / 2) % N : N - 1), 1'b0);
         checks++;
         if (obs() !== model_vec())
            begin failures++; $display("FAIL seq_model t=%0d got=%b want=%b", t, obs(), model_vec()); end
         if (health && first_h < 0) first_h = t;
         if (err_pulse || to_pulse) pulse_seen = 1;
      end
      checks++;
      if (first_h != 30 + LAT)
         begin failures++; $display("FAIL seq_health_edge got=%0d want=%0d", first_h, 30 + LAT); end
      checks++;
      if (pulse_seen)
         begin failures++; $display("FAIL seq_no_pulse got=1 want=0"); end
   endtask

   task automatic test_skip();
      int seq[$];
      int first_e = -1;
      int n_err = 0;
      seq = {0, 1, 2, 4, 0};
      for (int i = 1; i < N; i++) seq.push_back(i);
      for (int i = 0; i < N; i++) seq.push_back(i);
      for (int i = 0; i <= LAT; i++) seq.push_back(N - 1);
      foreach (seq[t]) begin
         tick(code(seq[t]), 1'b0);
         checks++;
         if (obs() !== model_vec())
            begin failures++; $display("FAIL skip_model t=%0d got=%b want=%b", t, obs(), model_vec()); end
         if (err_pulse) begin n_err++; if (first_e < 0) first_e = t; end
      end
      checks++;
      if (first_e != 3 + LAT || n_err != 1)
         begin failures++; $display("FAIL skip_err_pulse got=t%0d/n%0d want=t%0d/n1", first_e, n_err, 3 + LAT); end
      checks++;
      if (fault_cnt !== 2'd1 || health !== 1'b1)
         begin failures++; $display("FAIL skip_recover got=f%0d/h%b want=f1/h1", fault_cnt, health); end
   endtask

   task automatic test_timeout();
      int seq[$];
      int first_to = -1;
      int n_to = 0;
      for (int i = 0; i < N; i++) seq.push_back(i);
      seq.push_back(0); seq.push_back(1); seq.push_back(2);
      while (seq.size() < 120 + LAT) seq.push_back(3);
      foreach (seq[t]) begin
         tick(code(seq[t]), 1'b0);
         checks++;
         if (obs() !== model_vec())
            begin failures++; $display("FAIL to_model t=%0d got=%b want=%b", t, obs(), model_vec()); end
         if (to_pulse) begin n_to++; if (first_to < 0) first_to = t; end
      end
      checks++;
      if (first_to != 107 + LAT || n_to != 1)
         begin failures++; $display("FAIL to_edge got=t%0d/n%0d want=t%0d/n1", first_to, n_to, 107 + LAT); end
      checks++;
      if (fault_cnt !== 2'd2 || health !== 1'b0)
         begin failures++; $display("FAIL to_after got=f%0d/h%b want=f2/h0", fault_cnt, health); end
   endtask

   task automatic test_race();
      int seq[$];
      int first_to = -1;
      bit h_mid = 0;
      seq.push_back(0);
      for (int i = 1; i < N; i++) seq.push_back(i);
      for (int i = 0; i < N; i++) seq.push_back(i);
      while (seq.size() < 109) seq.push_back(0);
      for (int i = 1; i < N; i++) seq.push_back(i);
      while (seq.size() < 221 + LAT) seq.push_back(N - 1);
      foreach (seq[t]) begin
         tick(code(seq[t]), 1'b0);
         checks++;
         if (obs() !== model_vec())
            begin failures++; $display("FAIL race_model t=%0d got=%b want=%b", t, obs(), model_vec()); end
         if (to_pulse && first_to < 0) first_to = t;
         if (t == 210 + LAT) h_mid = health;
      end
      checks++;
      if (first_to != 215 + LAT)
         begin failures++; $display("FAIL race_to_edge got=%0d want=%0d", first_to, 215 + LAT); end
      checks++;
      if (!h_mid)
         begin failures++; $display("FAIL race_health got=0 want=1"); end
   endtask

   task automatic test_fault_sat();
      int seq[$];
      bit clr_q[$];
      int clr_at;
      int n_err = 0;
      tick(code(N - 1), 1'b1);
      checks++;
      if (fault_cnt !== 2'd0)
         begin failures++; $display("FAIL clr_only got=%0d want=0", fault_cnt); end
      for (int i = 0; i < 5; i++) begin seq.push_back(0); seq.push_back(2); end
      for (int i = 0; i <= LAT; i++) seq.push_back(2);
      foreach (seq[t]) begin
         tick(code(seq[t]), 1'b0);
         checks++;
         if (obs() !== model_vec())
            begin failures++; $display("FAIL sat_model t=%0d got=%b want=%b", t, obs(), model_vec()); end
         if (err_pulse) n_err++;
      end
      checks++;
      if (fault_cnt !== 2'd3 || n_err != 5)
         begin failures++; $display("FAIL sat_value got=f%0d/e%0d want=f3/e5", fault_cnt, n_err); end
      seq.delete();
      for (int i = 0; i < LAT + 2; i++) seq.push_back(0);
      seq.push_back(2);
      for (int i = 0; i < LAT + 2; i++) seq.push_back(2);
      clr_at = LAT + 2 + LAT;
      foreach (seq[t]) clr_q.push_back(t == clr_at);
      foreach (seq[t]) begin
         tick(code(seq[t]), clr_q[t]);
         checks++;
         if (obs() !== model_vec())
            begin failures++; $display("FAIL clrf_model t=%0d got=%b want=%b", t, obs(), model_vec()); end
      end
      checks++;
      if (fault_cnt !== 2'd1)
         begin failures++; $display("FAIL clr_with_fault got=%0d want=1", fault_cnt); end
   endtask

   task automatic test_random();
      int p = 0;
      int stall = 0;
      int r;
      bit clr;
      for (int t = 0; t < 1500; t++) begin
         r = $urandom_range(0, 99);
         if (stall > 0) stall--;
         else if (r < 45) p = (p + 1) % N;
         else if (r < 48) p = $urandom_range(0, N - 1);
         else if (r < 49) stall = $urandom_range(90, 130);
         clr = ($urandom_range(0, 49) == 0);
         tick(code(p), clr);
         checks++;
         if (obs() !== model_vec())
            begin failures++; $display("FAIL rand_model t=%0d got=%b want=%b", t, obs(), model_vec()); end
      end
   endtask

   task automatic test_reset_mid();
      int seq[$];
      int n_err = 0;
      reset_n = 1'b0;
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      seq = {0, 2};
      for (int i = 0; i < 2 * N; i++) seq.push_back(i % N);
      seq.push_back(0); seq.push_back(1); seq.push_back(2);
      for (int i = 0; i < LAT; i++) seq.push_back(2);
      foreach (seq[t]) begin
         tick(code(seq[t]), 1'b0);
         checks++;
         if (obs() !== model_vec())
            begin failures++; $display("FAIL mid_model t=%0d got=%b want=%b", t, obs(), model_vec()); end
      end
      checks++;
      if (health !== 1'b1 || fault_cnt !== 2'd1)
         begin failures++; $display("FAIL mid_pre got=h%b/f%0d want=h1/f1", health, fault_cnt); end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (obs() !== '0)
         begin failures++; $display("FAIL mid_async got=%b want=%b", obs(), {(FCNT_W+3){1'b0}}); end
      model_reset();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      seq = {1, 1, 1, 1, 2};
      for (int i = 0; i < N; i++) seq.push_back(i);
      foreach (seq[t]) begin
         tick(code(seq[t]), 1'b0);
         checks++;
         if (obs() !== model_vec())
            begin failures++; $display("FAIL post_model t=%0d got=%b want=%b", t, obs(), model_vec()); end
         if (t < 5 && (err_pulse || to_pulse)) n_err++;
      end
      checks++;
      if (n_err != 0)
         begin failures++; $display("FAIL post_idle_pulse got=%0d want=0", n_err); end
   endtask

   initial begin
      test_reset();
      test_sequences();
      test_skip();
      test_timeout();
      test_race();
      test_fault_sat();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
